// File: rtl/reg_bank_decoder_pkg.sv
// Shared types and helpers for the register-bank access decoder.
package reg_dec_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  localparam int unsigned MAX_WAIT_STATES = 15;

  // Wait counter must be able to hold WAIT_STATES-1 but never be zero bits wide.
  function automatic int unsigned cnt_width(input int unsigned ws);
    int unsigned w;
    w = $clog2(ws + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_bank_decoder_wait_cnt.sv
// Loadable down-counter that times the wait states before a response.
module reg_dec_wait_cnt
  import reg_dec_pkg::*;
#(
  parameter int unsigned WIDTH = cnt_width(MAX_WAIT_STATES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/reg_bank_decoder.sv
// Register-bank access decoder: one host request -> one-hot write strobe or muxed read, then one ack.
// Optional error response on out-of-range accesses with REG_DEC_ERR_RESP_EN.
module reg_bank_decoder
  import reg_dec_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel_en,
  input  logic                          wr_rd_s,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [W_WIDTH-1:0]            wdata,
  input  logic [NUM_REGS*W_WIDTH-1:0]   reg_rdata_in,
  output logic [NUM_REGS-1:0]           wr_en,
  output logic [W_WIDTH-1:0]            wr_data,
  output logic [W_WIDTH-1:0]            rd_data,
  output logic                          ack,
  output logic                          err
);

  localparam int unsigned WS    = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam int unsigned CNT_W = cnt_width(WS);
  localparam logic [CNT_W-1:0] LOAD_VAL = (WS > 0) ? CNT_W'(WS - 1) : '0;
  localparam logic [ADDR_W:0]  BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]  NREG_EXT = (ADDR_W+1)'(NUM_REGS);

  state_e               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_wr;
  logic [W_WIDTH-1:0]   r_wdata;
  logic [W_WIDTH-1:0]   r_rd_capt;

  logic                 w_load;
  logic                 w_done;
  logic [ADDR_W-1:0]    w_dec_addr;
  logic [ADDR_W:0]      w_idx;
  logic                 w_in_range;
  logic [NUM_REGS-1:0]  w_onehot;
  logic [W_WIDTH-1:0]   w_rd_mux;

  assign w_load = (r_state == IDLE) && sel_en;

  reg_dec_wait_cnt #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .value (LOAD_VAL),
    .done  (w_done)
  );

  // With no wait states RESP is entered straight from IDLE, so decode the live address there.
  assign w_dec_addr = (r_state == IDLE) ? addr : r_addr;
  assign w_idx      = {1'b0, w_dec_addr} - BASE_EXT;
  assign w_in_range = ({1'b0, w_dec_addr} >= BASE_EXT) && (w_idx < NREG_EXT);

  always_comb begin
    w_onehot = '0;
    w_rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_in_range && (w_idx == (ADDR_W+1)'(i))) begin
        w_onehot[i] = 1'b1;
        w_rd_mux    = reg_rdata_in[i*W_WIDTH +: W_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_rd_capt <= '0;
      wr_en     <= '0;
      wr_data   <= '0;
      rd_data   <= '0;
      ack       <= 1'b0;
    end else begin
      wr_en   <= '0;
      rd_data <= '0;
      ack     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sel_en) begin
            r_addr  <= addr;
            r_wr    <= wr_rd_s;
            r_wdata <= wdata;
            if (WS > 0) begin
              r_state <= WAIT;
            end else begin
              r_state   <= RESP;
              r_rd_capt <= w_rd_mux;
            end
          end
        end
        WAIT: begin
          if (!sel_en) begin
            r_state <= IDLE;
          end else if (w_done) begin
            r_state   <= RESP;
            r_rd_capt <= w_rd_mux;
          end
        end
        RESP: begin
          r_state <= HOLD;
          ack     <= 1'b1;
          if (w_in_range) begin
            if (r_wr) begin
              wr_en   <= w_onehot;
              wr_data <= r_wdata;
            end else begin
              rd_data <= r_rd_capt;
            end
          end
        end
        HOLD: begin
          if (!sel_en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef REG_DEC_ERR_RESP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= (r_state == RESP) && !w_in_range;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_decoder.sv
// Self-checking bench: three decoder configurations against a transaction-level model plus literal checks.
module tb_reg_bank_decoder;

`ifdef REG_DEC_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel   [3];
  logic        wr    [3];
  logic [3:0]  addr  [3];
  logic [7:0]  wd    [3];
  logic [31:0] rdata [3];
  logic [3:0]  o_wren [3];
  logic [7:0]  o_wrd  [3];
  logic [7:0]  o_rd   [3];
  logic        o_ack  [3];
  logic        o_err  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_bank_decoder #(.NUM_REGS(4), .W_WIDTH(8), .ADDR_W(4), .BASE_ADDR(0), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel[0]), .wr_rd_s(wr[0]), .addr(addr[0]), .wdata(wd[0]),
    .reg_rdata_in(rdata[0]), .wr_en(o_wren[0]), .wr_data(o_wrd[0]), .rd_data(o_rd[0]),
    .ack(o_ack[0]), .err(o_err[0]));

  reg_bank_decoder #(.NUM_REGS(4), .W_WIDTH(8), .ADDR_W(4), .BASE_ADDR(0), .WAIT_STATES(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel[1]), .wr_rd_s(wr[1]), .addr(addr[1]), .wdata(wd[1]),
    .reg_rdata_in(rdata[1]), .wr_en(o_wren[1]), .wr_data(o_wrd[1]), .rd_data(o_rd[1]),
    .ack(o_ack[1]), .err(o_err[1]));

  reg_bank_decoder #(.NUM_REGS(4), .W_WIDTH(8), .ADDR_W(4), .BASE_ADDR(4), .WAIT_STATES(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel[2]), .wr_rd_s(wr[2]), .addr(addr[2]), .wdata(wd[2]),
    .reg_rdata_in(rdata[2]), .wr_en(o_wren[2]), .wr_data(o_wrd[2]), .rd_data(o_rd[2]),
    .ack(o_ack[2]), .err(o_err[2]));

  function automatic int ws_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int base_of(input int d);
    return (d == 2) ? 4 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = free, 1 = request pending (k edges until response), 2 = responded, awaiting release.
  int          phase [3];
  int          k     [3];
  logic        c_wr  [3];
  int          c_addr[3];
  logic [7:0]  c_wd  [3];
  logic [3:0]  e_wren[3];
  logic [7:0]  e_wrd [3];
  logic [7:0]  e_rd  [3];
  logic        e_ack [3];
  logic        e_err [3];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        phase[d] = 0; k[d] = 0;
        e_wren[d] = '0; e_wrd[d] = '0; e_rd[d] = '0; e_ack[d] = 1'b0; e_err[d] = 1'b0;
      end else begin
        e_wren[d] = '0; e_rd[d] = '0; e_ack[d] = 1'b0; e_err[d] = 1'b0;
        case (phase[d])
          0: if (sel[d]) begin
               c_wr[d] = wr[d]; c_addr[d] = int'(addr[d]); c_wd[d] = wd[d];
               k[d] = ws_of(d) + 1; phase[d] = 1;
             end
          1: if (k[d] == 1) begin
               int idx;
               idx = c_addr[d] - base_of(d);
               e_ack[d] = 1'b1;
               phase[d] = 2;
               if (idx >= 0 && idx < 4) begin
                 if (c_wr[d]) begin
                   e_wren[d] = 4'(1 << idx);
                   e_wrd[d]  = c_wd[d];
                 end else begin
                   e_rd[d] = rdata[d][idx*8 +: 8];
                 end
               end else begin
                 e_err[d] = ERR_EN;
               end
             end else if (!sel[d]) begin
               phase[d] = 0;
             end else begin
               k[d] = k[d] - 1;
             end
          default: if (!sel[d]) phase[d] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d.wr_en", d),   o_wren[d], e_wren[d]);
      chk($sformatf("d%0d.wr_data", d), o_wrd[d],  e_wrd[d]);
      chk($sformatf("d%0d.rd_data", d), o_rd[d],   e_rd[d]);
      chk($sformatf("d%0d.ack", d),     o_ack[d],  e_ack[d]);
      chk($sformatf("d%0d.err", d),     o_err[d],  e_err[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic w, input logic [3:0] a, input logic [7:0] v);
    sel[d] = s; wr[d] = w; addr[d] = a; wd[d] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 4'h0, 8'h00);
    rdata[0] = 32'hDD_CC_BB_AA;
    rdata[1] = 32'h11_22_3C_44;
    rdata[2] = 32'h78_56_34_12;
    repeat (2) step();
    chk("reset_ack", o_ack[0], 1'b0);
    chk("reset_wr_en", o_wren[1], 4'b0000);
    rst_n = 1'b1;
    step();

    // WS=0 write addr 2, held 4 cycles
    drive(0, 1'b1, 1'b1, 4'd2, 8'hA5);
    step();
    chk("t1_ack_early", o_ack[0], 1'b0);
    step();
    chk("t1_wr_en", o_wren[0], 4'b0100);
    chk("t1_wr_data", o_wrd[0], 8'hA5);
    chk("t1_ack", o_ack[0], 1'b1);
    step();
    chk("t1_ack_once", o_ack[0], 1'b0);
    chk("t1_wr_data_hold", o_wrd[0], 8'hA5);
    step();
    chk("t1_ack_held", o_ack[0], 1'b0);
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();

    // WS=3 read addr 1
    drive(1, 1'b1, 1'b0, 4'd1, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_rd_before", o_rd[1], 8'h00);
      chk("t2_ack_before", o_ack[1], 1'b0);
    end
    step();
    chk("t2_ack", o_ack[1], 1'b1);
    chk("t2_rd", o_rd[1], 8'h3C);
    step();
    chk("t2_rd_after", o_rd[1], 8'h00);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();

    // BASE=4: out-of-range read addr 9
    drive(2, 1'b1, 1'b0, 4'd9, 8'h00);
    repeat (2) step();
    chk("t3_ack", o_ack[2], 1'b1);
    chk("t3_rd", o_rd[2], 8'h00);
    chk("t3_wr_en", o_wren[2], 4'b0000);
    chk("t3_err", o_err[2], ERR_EN);
    drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();
    // below base write, then edges of the window
    drive(2, 1'b1, 1'b1, 4'd3, 8'h77);
    repeat (2) step();
    chk("t3b_wr_en", o_wren[2], 4'b0000);
    drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();
    drive(2, 1'b1, 1'b1, 4'd7, 8'h9E);
    repeat (2) step();
    chk("t3c_wr_en", o_wren[2], 4'b1000);
    drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();
    drive(2, 1'b1, 1'b0, 4'd4, 8'h00);
    repeat (2) step();
    chk("t3d_rd", o_rd[2], 8'h12);
    drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();
    // d0 just past the last slot
    drive(0, 1'b1, 1'b1, 4'd4, 8'h33);
    repeat (2) step();
    chk("t3e_wr_en", o_wren[0], 4'b0000);
    chk("t3e_ack", o_ack[0], 1'b1);
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();

    // WS=3 abort after one wait cycle, then a normal read
    drive(1, 1'b1, 1'b1, 4'd2, 8'hEE);
    repeat (2) step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_no_ack", o_ack[1], 1'b0);
      chk("t4_no_wr_en", o_wren[1], 4'b0000);
    end
    drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
    repeat (5) step();
    chk("t4_ack", o_ack[1], 1'b1);
    chk("t4_rd", o_rd[1], 8'h11);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();

    // reset during WAIT
    drive(1, 1'b1, 1'b1, 4'd0, 8'h5A);
    repeat (5) step();
    chk("t5_pre_wr_en", o_wren[1], 4'b0001);
    chk("t5_pre_wr_data", o_wrd[1], 8'h5A);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) step();
    drive(1, 1'b1, 1'b0, 4'd2, 8'h00);
    repeat (2) step();
    #2 rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    chk("t5_wr_data", o_wrd[1], 8'h00);
    chk("t5_wr_data_d0", o_wrd[0], 8'h00);
    chk("t5_ack", o_ack[1], 1'b0);
    chk("t5_rd", o_rd[1], 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_ack", o_ack[1], 1'b0);
    end

    // back-to-back writes on d0, sel low one cycle between
    drive(0, 1'b1, 1'b1, 4'd0, 8'h11);
    repeat (2) step();
    chk("t6_wr_en_a", o_wren[0], 4'b0001);
    chk("t6_ack_a", o_ack[0], 1'b1);
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    drive(0, 1'b1, 1'b1, 4'd3, 8'h22);
    step();
    chk("t6_gap", o_ack[0], 1'b0);
    step();
    chk("t6_wr_en_b", o_wren[0], 4'b1000);
    chk("t6_wr_data_b", o_wrd[0], 8'h22);
    chk("t6_ack_b", o_ack[0], 1'b1);
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_decoder.md
Name: reg_bank_decoder

Overview:
Parametrised register-bank access decoder for the switch configuration interface. One host request (sel_en, wr_rd_s, addr, wdata) is decoded across NUM_REGS contiguous register slots starting at BASE_ADDR. Each accepted access produces a one-cycle write strobe or read capture, followed by a single ack pulse.
Generalises the single-register decoder with:
- a one-hot write-enable vector
- a muxed read path
- programmable wait states
- one-shot handshaking
- out-of-range handling

Parameters:
- NUM_REGS, 4, number of register slots (≥1)
- W_WIDTH, 8, data width of each register
- ADDR_W, 4, host address width; must satisfy BASE_ADDR+NUM_REGS ≤ 2**ADDR_W
- BASE_ADDR, 0, address of slot 0
- WAIT_STATES, 0, extra cycles inserted before ack (0..15)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- sel_en, input, 1, host request; held high until ack is seen
- wr_rd_s, input, 1, 1 = write, 0 = read
- addr, input, ADDR_W, host address
- wdata, input, W_WIDTH, host write data
- reg_rdata_in, input, NUM_REGS*W_WIDTH, flattened register contents; slot i is at bits [i*W_WIDTH +: W_WIDTH]
- wr_en, output, NUM_REGS, one-hot write strobe
- wr_data, output, W_WIDTH, latched write data; valid while wr_en is non-zero
- rd_data, output, W_WIDTH, read data; valid only in the ack cycle
- ack, output, 1, one-cycle access-complete pulse
- err, output, 1, error flag, coincident with ack

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low, all outputs are 0, the FSM is in IDLE and the wait counter is 0. Reset mid-access aborts the access silently; no ack or wr_en appears after release.
- All outputs are registered.
- States:
  - IDLE → WAIT, when sel_en=1 and WAIT_STATES>0.
  - IDLE → RESP, when sel_en=1 and WAIT_STATES=0.
  - WAIT → RESP, when the counter reaches 0.
  - WAIT → IDLE, when sel_en drops (abort: no ack, no wr_en).
  - RESP → HOLD, unconditionally.
  - HOLD → IDLE, when sel_en=0.
- Capture: at the IDLE edge that samples sel_en=1, latch addr, wr_rd_s and wdata. Later changes on these inputs are ignored until the next IDLE.
- Index: idx = addr − BASE_ADDR, computed in ADDR_W+1 bits. The access is in range iff addr ≥ BASE_ADDR and idx < NUM_REGS.
- WAIT: the counter loads WAIT_STATES−1 on entry and decrements each cycle. Its width is max(1, $clog2(WAIT_STATES+1)).
- Latency: if the request is sampled at edge N, the ack/wr_en/rd_data outputs are high during the cycle after edge N+1+WAIT_STATES. With WAIT_STATES=0 the latency is one cycle.
- Write, in range: wr_en[idx]=1, wr_data=latched wdata, ack=1, all for exactly one cycle.
- Read, in range: rd_data = reg_rdata_in slot idx, sampled at the edge entering RESP; ack=1 for one cycle; rd_data returns to 0 afterwards.
- Out of range: wr_en stays 0 and rd_data=0. For ack and err, see Optional Feature.
- One-shot rule: a held sel_en yields exactly one ack. The next access requires sel_en to go low (HOLD → IDLE) and then high again.
- A sel_en low→high transition in the same cycle as the HOLD → IDLE transition is not accepted until the following IDLE cycle.
- wr_data holds its last latched value outside strobes.
- err=0 except in an ack cycle.

Optional Feature:
- Macro REG_DEC_ERR_RESP_EN.
- Defined: an out-of-range access gives ack=1 and err=1 in the RESP cycle.
- Defined: a write with an empty wdata-to-slot mapping still gives no wr_en.
- Undefined: an out-of-range access gives ack=1 and err=0 (silent completion).
- Undefined: the err output is tied to 0.
- In-range behaviour is identical in both builds.

Decomposition:
- Package reg_dec_pkg contains:
  - the state enum {IDLE, WAIT, RESP, HOLD}, 2 bits
  - localparam MAX_WAIT_STATES=15
  - a function computing the counter width
- Sub-module reg_dec_wait_cnt holds the loadable down-counter:
  - inputs: load, value
  - output: done
- The top level keeps the FSM, capture registers, decode and read mux.

Test Plan:
- WAIT_STATES=0, write addr=2, wdata=8'hA5, sel_en held 4 cycles → wr_en=4'b0100, wr_data=8'hA5, ack=1 one cycle after the sample edge; ack not repeated while sel_en is held.
- WAIT_STATES=3, read addr=1 with slot1=8'h3C → ack and rd_data=8'h3C four cycles after the sample edge; rd_data=0 before and after.
- BASE_ADDR=4, read addr=9 (out of range) → wr_en=0, rd_data=0, ack=1.
  - With REG_DEC_ERR_RESP_EN: err=1.
  - Without it: err=0.
- WAIT_STATES=3, sel_en dropped after 1 wait cycle → no ack, no wr_en; a new request afterwards completes normally.
- rst_n asserted during WAIT → all outputs 0 immediately; no ack after release.
- Back-to-back writes to addr 0 then 3, with sel_en low for 1 cycle between them → two single-cycle strobes 4'b0001 then 4'b1000, two acks.
